// File: rtl/led_mmio.sv
// led_mmio: memory-mapped LED peripheral.
// A two-state request/response bus configures five word registers.
// The board LEDs are driven in direct, blink or PWM-dimmed mode.
module led_mmio #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_F000,
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned BLINK_W   = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_valid,
  input  logic        bus_write,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic        bus_ready,
  output logic [31:0] bus_rdata,
  output logic [7:0]  led
);

  typedef enum logic {IDLE, RESP} state_t;

  localparam logic [2:0] IDX_LED    = 3'd0;
  localparam logic [2:0] IDX_CTRL   = 3'd1;
  localparam logic [2:0] IDX_PERIOD = 3'd2;
  localparam logic [2:0] IDX_DUTY   = 3'd3;
  localparam logic [2:0] IDX_STATUS = 3'd4;

  // Bus transaction state
  state_t               state_q;
  logic                 ready_q;
  logic [31:0]          rdata_q;
  logic                 write_q;
  logic                 hit_q;
  logic [2:0]           idx_q;
  logic [BLINK_W-1:0]   wdata_q;

  // Software-visible registers
  logic [7:0]           ledData_q;
  logic [1:0]           mode_q;
  logic [BLINK_W-1:0]   blinkPeriod_q;
  logic [PWM_BITS-1:0]  pwmDuty_q;

  // Display timing state
  logic [BLINK_W-1:0]   blinkCnt_q, blinkCnt_d;
  logic                 blinkPhase_q, blinkPhase_d;
  logic [BLINK_W-1:0]   periodLast;
  logic [PWM_BITS-1:0]  pwmCnt_q;
  logic [7:0]           led_q, led_d;

  // Request decode
  logic [31:0]          reqOffset;
  logic                 reqHit;
  logic [2:0]           reqIdx;
  logic [31:0]          readData_d;
  logic                 commitWr;
  logic                 cfgWr;
  logic                 unusedBits;

  // Offsets beyond STATUS, or addresses below the base (which wrap to huge
  // offsets), fall outside the window. The low two address bits are ignored.
  assign reqOffset  = bus_addr - ADDR_BASE;
  assign reqHit     = (reqOffset[31:5] == 27'd0) && (reqOffset[4:2] <= IDX_STATUS);
  assign reqIdx     = reqOffset[4:2];
  assign unusedBits = ^{reqOffset[1:0], bus_wdata[31:BLINK_W]};

  // A store commits on the edge that ends the RESP cycle.
  assign commitWr = (state_q == RESP) && write_q && hit_q;
  assign cfgWr    = commitWr && ((idx_q == IDX_CTRL) || (idx_q == IDX_PERIOD));

  // A period of zero behaves like a period of one.
  assign periodLast = (blinkPeriod_q == '0) ? '0 : blinkPeriod_q - BLINK_W'(1);

  assign bus_ready = ready_q;
  assign bus_rdata = rdata_q;
  assign led       = led_q;

  // Load data is selected from the incoming address at the latch edge.
  always_comb begin
    readData_d = '0;
    if (reqHit) begin
      case (reqIdx)
        IDX_LED:    readData_d[7:0]          = ledData_q;
        IDX_CTRL:   readData_d[1:0]          = mode_q;
        IDX_PERIOD: readData_d[BLINK_W-1:0]  = blinkPeriod_q;
        IDX_DUTY:   readData_d[PWM_BITS-1:0] = pwmDuty_q;
        IDX_STATUS: readData_d[1:0]          = {blinkPhase_q, 1'b1};
        default:    readData_d               = '0;
      endcase
    end
  end

  // Blink counter next state; a CTRL/BLINK_PERIOD store restarts the blink.
  always_comb begin
    blinkCnt_d   = blinkCnt_q + BLINK_W'(1);
    blinkPhase_d = blinkPhase_q;
    if (cfgWr) begin
      blinkCnt_d   = '0;
      blinkPhase_d = 1'b1;
    end else if (blinkCnt_q == periodLast) begin
      blinkCnt_d   = '0;
      blinkPhase_d = ~blinkPhase_q;
    end
  end

  // LED drive selection for the current display mode.
  always_comb begin
    led_d = '0;
    case (mode_q)
      2'd0:    led_d = ledData_q;
      2'd1:    led_d = blinkPhase_q ? ledData_q : 8'd0;
      2'd2:    led_d = (pwmCnt_q < pwmDuty_q) ? ledData_q : 8'd0;
      default: led_d = 8'd0;
    endcase
  end

  // Bus FSM: latch a request in IDLE, pulse ready with load data in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      rdata_q <= '0;
      write_q <= 1'b0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus_valid) begin
            state_q <= RESP;
            ready_q <= 1'b1;
            rdata_q <= bus_write ? 32'd0 : readData_d;
            write_q <= bus_write;
            hit_q   <= reqHit;
            idx_q   <= reqIdx;
            wdata_q <= bus_wdata[BLINK_W-1:0];
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          rdata_q <= '0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          rdata_q <= '0;
        end
      endcase
    end
  end

  // Register file update on a committed in-window store; STATUS is read-only.
  always_ff @(posedge clk) begin
    if (rst) begin
      ledData_q     <= '0;
      mode_q        <= '0;
      blinkPeriod_q <= '0;
      pwmDuty_q     <= '0;
    end else if (commitWr) begin
      case (idx_q)
        IDX_LED:    ledData_q     <= wdata_q[7:0];
        IDX_CTRL:   mode_q        <= wdata_q[1:0];
        IDX_PERIOD: blinkPeriod_q <= wdata_q[BLINK_W-1:0];
        IDX_DUTY:   pwmDuty_q     <= wdata_q[PWM_BITS-1:0];
        default:    ;
      endcase
    end
  end

  // Free-running blink and PWM counters, active in every mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b1;
      pwmCnt_q     <= '0;
    end else begin
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
      pwmCnt_q     <= pwmCnt_q + PWM_BITS'(1);
    end
  end

  // Registered LED output.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

endmodule

// File: tb/tb_led_mmio.sv
// tb_led_mmio: self-checking bench for the LED peripheral.
// A behavioural model tracks registers plus cycle counts since reset and since
// the last blink restart, and predicts led/ready/rdata every cycle.
module tb_led_mmio;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busValid = 1'b0;
  logic        busWrite = 1'b0;
  logic [31:0] busAddr = '0;
  logic [31:0] busWdata = '0;
  logic        busReady;
  logic [31:0] busRdata;
  logic [7:0]  ledOut;

  int checks = 0;
  int errors = 0;

  led_mmio dut (
    .clk       (clk),
    .rst       (rst),
    .bus_valid (busValid),
    .bus_write (busWrite),
    .bus_addr  (busAddr),
    .bus_wdata (busWdata),
    .bus_ready (busReady),
    .bus_rdata (busRdata),
    .led       (ledOut)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  mLed = '0;
  logic [1:0]  mMode = '0;
  logic [23:0] mPer = '0;
  logic [7:0]  mDuty = '0;
  int          cyc = 0;
  int          cfgCyc = 0;
  bit          pend = 1'b0;
  bit          pW = 1'b0;
  logic [31:0] pA = '0;
  logic [31:0] pD = '0;
  logic [31:0] pRd = '0;
  logic [7:0]  expLed = '0;
  bit          monOn = 1'b0;

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    string       name;
  } busVec_t;

  busVec_t vecs[15];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Word index of an address inside the 5-word window, or -1 outside it.
  function automatic int winIdx(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'h0000_F000;
    return (off < 32'h14) ? int'(off >> 2) : -1;
  endfunction

  // Blink phase: starts at 1 on each restart and flips every period cycles.
  function automatic bit phaseNow();
    int pe;
    pe = (mPer == 24'd0) ? 1 : int'(mPer);
    return (((cyc - cfgCyc) / pe) % 2) == 0;
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    case (winIdx(a))
      0:       return {24'd0, mLed};
      1:       return {30'd0, mMode};
      2:       return {8'd0, mPer};
      3:       return {24'd0, mDuty};
      4:       return {30'd0, phaseNow(), 1'b1};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [7:0] modelLed();
    case (mMode)
      2'd0:    return mLed;
      2'd1:    return phaseNow() ? mLed : 8'd0;
      2'd2:    return ((cyc % 256) < int'(mDuty)) ? mLed : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  task automatic modelCommit(input logic [31:0] a, input logic [31:0] d);
    case (winIdx(a))
      0: mLed = d[7:0];
      1: begin mMode = d[1:0]; cfgCyc = cyc + 1; end
      2: begin mPer = d[23:0]; cfgCyc = cyc + 1; end
      3: mDuty = d[7:0];
      default: ;
    endcase
  endtask

  // Model advances on each rising edge using pre-edge state.
  always @(posedge clk) begin : modelProc
    logic [7:0] nextLed;
    if (rst) begin
      mLed = '0; mMode = '0; mPer = '0; mDuty = '0;
      cyc = 0; cfgCyc = 0; pend = 1'b0; pRd = '0; expLed = '0;
    end else begin
      nextLed = modelLed();
      if (pend) begin
        if (pW) modelCommit(pA, pD);
        pend = 1'b0;
      end else if (busValid) begin
        pend = 1'b1;
        pW   = busWrite;
        pA   = busAddr;
        pD   = busWdata;
        pRd  = busWrite ? 32'd0 : modelRead(busAddr);
      end
      expLed = nextLed;
      cyc++;
    end
  end

  // Continuous comparison of all outputs against the model.
  always @(negedge clk) begin
    if (monOn) begin
      checkOutput("mon led", {24'd0, ledOut}, {24'd0, expLed});
      checkOutput("mon ready", {31'd0, busReady}, {31'd0, pend});
      checkOutput("mon rdata", busRdata, pend ? pRd : 32'd0);
    end
  end

  // Issue one request at the current falling edge and wait for ready.
  task automatic applyStimulus(input bit w, input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] rd, output int lat);
    busValid = 1'b1;
    busWrite = w;
    busAddr  = a;
    busWdata = d;
    lat = 0;
    rd  = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (busReady === 1'b1) begin
        lat = i;
        rd  = busRdata;
        break;
      end
    end
    busValid = 1'b0;
    busWrite = 1'b0;
    if (lat == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready timeout: got no ready, required within 8 cycles");
    end
  endtask

  task automatic doStore(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    int lat;
    applyStimulus(1'b1, a, d, rd, lat);
    checkOutput("store latency", lat, 1);
  endtask

  task automatic doLoad(input logic [31:0] a, input logic [31:0] exp, input string name);
    logic [31:0] rd;
    int lat;
    applyStimulus(1'b0, a, 32'd0, rd, lat);
    checkOutput(name, rd, exp);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    logic [31:0] rd;
    int lat;
    int onCnt;
    int otherCnt;

    vecs[0]  = '{1'b1, 32'h0000_F000, 32'h1234_56A5, 32'h0,        "wr led"};
    vecs[1]  = '{1'b0, 32'h0000_F000, 32'h0,         32'hA5,       "rd led"};
    vecs[2]  = '{1'b0, 32'h0000_F003, 32'h0,         32'hA5,       "rd led low bits"};
    vecs[3]  = '{1'b1, 32'h0000_F004, 32'hFFFF_FFFC, 32'h0,        "wr ctrl"};
    vecs[4]  = '{1'b0, 32'h0000_F004, 32'h0,         32'h0,        "rd ctrl"};
    vecs[5]  = '{1'b1, 32'h0000_F008, 32'hFFFF_FFFF, 32'h0,        "wr period"};
    vecs[6]  = '{1'b0, 32'h0000_F008, 32'h0,         32'h00FF_FFFF, "rd period"};
    vecs[7]  = '{1'b1, 32'h0000_F00C, 32'hABCD_EF80, 32'h0,        "wr duty"};
    vecs[8]  = '{1'b0, 32'h0000_F00C, 32'h0,         32'h80,       "rd duty"};
    vecs[9]  = '{1'b1, 32'h0000_F010, 32'h0,         32'h0,        "wr status"};
    vecs[10] = '{1'b1, 32'h0000_F014, 32'hFFFF_FFFF, 32'h0,        "wr f014"};
    vecs[11] = '{1'b0, 32'h0000_F014, 32'h0,         32'h0,        "rd f014"};
    vecs[12] = '{1'b1, 32'h0000_E000, 32'h0000_FFFF, 32'h0,        "wr below base"};
    vecs[13] = '{1'b0, 32'h0000_F000, 32'h0,         32'hA5,       "rd led after bad"};
    vecs[14] = '{1'b0, 32'h0000_F008, 32'h0,         32'h00FF_FFFF, "rd period after bad"};

    // Reset for three cycles
    rst = 1'b1;
    repeat (3) @(negedge clk);
    monOn = 1'b1;
    checkOutput("reset led", {24'd0, ledOut}, 32'd0);
    checkOutput("reset ready", {31'd0, busReady}, 32'd0);
    checkOutput("reset rdata", busRdata, 32'd0);
    rst = 1'b0;
    doLoad(32'h0000_F010, 32'h3, "status after reset");

    // Direct mode
    @(negedge clk);
    doStore(32'h0000_F000, 32'hA5);
    @(negedge clk);
    checkOutput("direct led before update", {24'd0, ledOut}, 32'd0);
    @(negedge clk);
    checkOutput("direct led", {24'd0, ledOut}, 32'hA5);
    doLoad(32'h0000_F000, 32'hA5, "direct readback");

    // Register map vectors
    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i].write, vecs[i].addr, vecs[i].wdata, rd, lat);
      checkOutput({vecs[i].name, " latency"}, lat, 1);
      checkOutput(vecs[i].name, rd, vecs[i].expRdata);
    end

    // Blink: period 4, first four cycles on
    @(negedge clk); doStore(32'h0000_F000, 32'hFF);
    @(negedge clk); doStore(32'h0000_F008, 32'd4);
    @(negedge clk); doStore(32'h0000_F004, 32'd1);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("blink p4", {24'd0, ledOut}, (i < 4) ? 32'hFF : 32'h0);
    end
    // Blink: period 0 toggles every cycle
    doStore(32'h0000_F008, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("blink p0", {24'd0, ledOut}, (i % 2 == 0) ? 32'hFF : 32'h0);
    end

    // PWM: duty 64 of 256
    @(negedge clk); doStore(32'h0000_F000, 32'h0F);
    @(negedge clk); doStore(32'h0000_F00C, 32'd64);
    @(negedge clk); doStore(32'h0000_F004, 32'd2);
    @(negedge clk);
    onCnt = 0; otherCnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (ledOut === 8'h0F) onCnt++;
      else if (ledOut !== 8'h00) otherCnt++;
    end
    checkOutput("pwm64 on count", onCnt, 64);
    checkOutput("pwm64 other values", otherCnt, 0);
    doStore(32'h0000_F00C, 32'd0);
    @(negedge clk);
    onCnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (ledOut !== 8'h00) onCnt++;
    end
    checkOutput("pwm0 on count", onCnt, 0);

    // Bad address and reserved mode
    @(negedge clk); doStore(32'h0000_F020, 32'hFF);
    @(negedge clk); doLoad(32'h0000_F020, 32'h0, "bad addr load");
    @(negedge clk); doLoad(32'h0000_F00C, 32'h0, "duty after bad store");
    @(negedge clk); doLoad(32'h0000_F000, 32'h0F, "led after bad store");
    @(negedge clk); doStore(32'h0000_F00C, 32'hFF);
    @(negedge clk); doStore(32'h0000_F004, 32'd3);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("reserved mode led", {24'd0, ledOut}, 32'h0);
    end

    // Reset during RESP discards the store
    busValid = 1'b1; busWrite = 1'b1; busAddr = 32'h0000_F000; busWdata = 32'h55;
    @(negedge clk);
    checkOutput("midop ready", {31'd0, busReady}, 32'd1);
    busValid = 1'b0; busWrite = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midop ready after rst", {31'd0, busReady}, 32'd0);
    checkOutput("midop led after rst", {24'd0, ledOut}, 32'd0);
    rst = 1'b0;
    doLoad(32'h0000_F000, 32'h0, "midop led data");
    @(negedge clk); doStore(32'h0000_F000, 32'h5A);
    @(negedge clk); doLoad(32'h0000_F000, 32'h5A, "after midop readback");

    // Randomized traffic checked by the model
    for (int n = 0; n < 250; n++) begin
      int pick;
      logic [31:0] a;
      logic [31:0] d;
      bit w;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      pick = int'($urandom_range(0, 7));
      case (pick)
        0, 1, 2, 3, 4: a = 32'h0000_F000 + 32'(4 * pick) + 32'($urandom_range(0, 3));
        5:             a = 32'h0000_F014;
        6:             a = 32'h0000_F020;
        default:       a = $urandom;
      endcase
      w = ($urandom_range(0, 1) == 1);
      d = $urandom;
      if (pick == 2) d = 32'($urandom_range(0, 9));
      applyStimulus(w, a, d, rd, lat);
      checkOutput("random latency", lat, 1);
    end

    repeat (5) @(negedge clk);
    monOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
